// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH general-purpose register file.
// Two combinational read ports, one clocked write port, entry 0 hardwired to zero.
// Reads see a same-cycle write through the bypass path.
// Reset is asynchronous and active-high, and it wins over any pending write.
module reg_file #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);

  // Entry 0 has no storage behind it; only entries 1..DEPTH-1 are real flops.
  logic [WIDTH-1:0] mem [1:DEPTH-1];

  // A write is live only with reset low and a nonzero target.
  logic wr_live;
  logic byp1;
  logic byp2;

  // Qualify the write strobe and the per-port bypass hits.
  always_comb begin
    wr_live = 1'b0;
    byp1    = 1'b0;
    byp2    = 1'b0;
    if (!reset && we && (waddr != '0)) begin
      wr_live = 1'b1;
      byp1    = (raddr1 == waddr);
      byp2    = (raddr2 == waddr);
    end
  end

  // Storage update: async clear of every entry; otherwise one write per edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_live) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port 1: zero under reset or for address 0, else bypass or stored value.
  always_comb begin
    rdata1 = '0;
    if (!reset && (raddr1 != '0)) begin
      if (byp1) begin
        rdata1 = wdata;
      end else begin
        rdata1 = mem[raddr1];
      end
    end
  end

  // Read port 2: same selection as port 1, independent address.
  always_comb begin
    rdata2 = '0;
    if (!reset && (raddr2 != '0)) begin
      if (byp2) begin
        rdata2 = wdata;
      end else begin
        rdata2 = mem[raddr2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed and randomized checks of reg_file against an array-based reference model.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  logic [31:0] model [32];
  int          check_cnt;
  int          pass_cnt;

  reg_file #(.WIDTH(32), .DEPTH(32), .AW(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value from the register-file rules.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (reset) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (we && (waddr == a)) return wdata;
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Advance one rising edge and commit any live write into the model.
  task automatic step();
    if (!reset && we && (waddr != 5'd0)) model[waddr] = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] addrs [3];
    addrs[0] = 5'd0; addrs[1] = 5'd5; addrs[2] = 5'd31;
    reset = 1'b1;
    clear_model();
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      raddr1 = addrs[k];
      raddr2 = addrs[k];
      #1;
      check_cnt++;
      if (rdata1 !== 32'h0) $display("FAIL reset_rd1 addr=%0d got=%h exp=%h", addrs[k], rdata1, 32'h0);
      else pass_cnt++;
      check_cnt++;
      if (rdata2 !== 32'h0) $display("FAIL reset_rd2 addr=%0d got=%h exp=%h", addrs[k], rdata2, 32'h0);
      else pass_cnt++;
    end
    reset = 1'b0;
    step();
    raddr1 = 5'd5;
    #1;
    check_cnt++;
    if (rdata1 !== 32'h0) $display("FAIL reset_release got=%h exp=%h", rdata1, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    raddr1 = 5'd1; raddr2 = 5'd2;
    step();
    we = 1'b0;
    raddr1 = 5'd5;
    #1;
    check_cnt++;
    if (rdata1 !== 32'hDEADBEEF) $display("FAIL write_read got=%h exp=%h", rdata1, 32'hDEADBEEF);
    else pass_cnt++;
  endtask

  task automatic test_zero_entry();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    check_cnt++;
    if (rdata1 !== 32'h0) $display("FAIL zero_pre_rd1 got=%h exp=%h", rdata1, 32'h0);
    else pass_cnt++;
    check_cnt++;
    if (rdata2 !== 32'h0) $display("FAIL zero_pre_rd2 got=%h exp=%h", rdata2, 32'h0);
    else pass_cnt++;
    step();
    we = 1'b0;
    #1;
    check_cnt++;
    if (rdata1 !== 32'h0) $display("FAIL zero_post_rd1 got=%h exp=%h", rdata1, 32'h0);
    else pass_cnt++;
    check_cnt++;
    if (rdata2 !== 32'h0) $display("FAIL zero_post_rd2 got=%h exp=%h", rdata2, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd7; wdata = 32'h1;
    step();
    wdata = 32'h2;
    raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    check_cnt++;
    if (rdata1 !== 32'h2) $display("FAIL bypass_pre_rd1 got=%h exp=%h", rdata1, 32'h2);
    else pass_cnt++;
    check_cnt++;
    if (rdata2 !== 32'h2) $display("FAIL bypass_pre_rd2 got=%h exp=%h", rdata2, 32'h2);
    else pass_cnt++;
    step();
    we = 1'b0;
    #1;
    check_cnt++;
    if (rdata1 !== 32'h2) $display("FAIL bypass_post_rd1 got=%h exp=%h", rdata1, 32'h2);
    else pass_cnt++;
    check_cnt++;
    if (rdata2 !== 32'h2) $display("FAIL bypass_post_rd2 got=%h exp=%h", rdata2, 32'h2);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    we = 1'b1; waddr = 5'd31; wdata = 32'hA5A5A5A5;
    step();
    wdata = 32'h5A5A5A5A;
    raddr1 = 5'd31; raddr2 = 5'd5;
    #1;
    check_cnt++;
    if (rdata1 !== 32'h5A5A5A5A) $display("FAIL midrst_bypass got=%h exp=%h", rdata1, 32'h5A5A5A5A);
    else pass_cnt++;
    #2;
    reset = 1'b1;
    clear_model();
    #1;
    check_cnt++;
    if (rdata1 !== 32'h0) $display("FAIL midrst_now_rd1 got=%h exp=%h", rdata1, 32'h0);
    else pass_cnt++;
    check_cnt++;
    if (rdata2 !== 32'h0) $display("FAIL midrst_now_rd2 got=%h exp=%h", rdata2, 32'h0);
    else pass_cnt++;
    step();
    reset = 1'b0;
    we = 1'b0;
    #1;
    check_cnt++;
    if (rdata1 !== 32'h0) $display("FAIL midrst_lost_rd1 got=%h exp=%h", rdata1, 32'h0);
    else pass_cnt++;
    check_cnt++;
    if (rdata2 !== 32'h0) $display("FAIL midrst_lost_rd2 got=%h exp=%h", rdata2, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_sweep();
    for (int i = 1; i < 32; i++) begin
      we = 1'b1;
      waddr = 5'(i);
      wdata = {8'(i), 24'($urandom)};
      step();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      check_cnt++;
      if (rdata1 !== exp_read(raddr1)) $display("FAIL sweep_rd1 addr=%0d got=%h exp=%h", raddr1, rdata1, exp_read(raddr1));
      else pass_cnt++;
      check_cnt++;
      if (rdata2 !== exp_read(raddr2)) $display("FAIL sweep_rd2 addr=%0d got=%h exp=%h", raddr2, rdata2, exp_read(raddr2));
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we     = 1'($urandom);
      waddr  = 5'($urandom);
      wdata  = $urandom;
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        clear_model();
      end
      #1;
      check_cnt++;
      if (rdata1 !== exp_read(raddr1)) $display("FAIL rand_rd1 n=%0d addr=%0d got=%h exp=%h", n, raddr1, rdata1, exp_read(raddr1));
      else pass_cnt++;
      check_cnt++;
      if (rdata2 !== exp_read(raddr2)) $display("FAIL rand_rd2 n=%0d addr=%0d got=%h exp=%h", n, raddr2, rdata2, exp_read(raddr2));
      else pass_cnt++;
      step();
      reset = 1'b0;
    end
    we = 1'b0;
  endtask

  initial begin
    check_cnt = 0;
    pass_cnt  = 0;
    reset  = 1'b1;
    we     = 1'b0;
    waddr  = 5'd0;
    wdata  = 32'h0;
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    clear_model();
    test_reset();
    test_write_read();
    test_zero_entry();
    test_bypass();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
